// File: rtl/gray_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_pkg : shared constants and state encoding for the gray sum stage    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gray_pkg;

  localparam int MANT_W      = 10;
  localparam int EXP_W       = 6;
  localparam int GUARD_W     = 2;
  localparam int PIXEL_WIDTH = 8;
  localparam int EXT_W       = MANT_W + GUARD_W;
  localparam int MAX_SHIFT   = EXT_W;
  localparam int SUM_W       = EXT_W + 2;
  localparam int CNT_W       = $clog2(MAX_SHIFT + 1);

  // Channel ordering shared with the fixed-point multiplier
  localparam int NUM_CH = 3;
  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;

  typedef logic [2:0] state_t;

  localparam state_t c_ST_IDLE    = 3'd0;
  localparam state_t c_ST_MAXEXP  = 3'd1;
  localparam state_t c_ST_ALIGN   = 3'd2;
  localparam state_t c_ST_ADD     = 3'd3;
  localparam state_t c_ST_CONVERT = 3'd4;
  localparam state_t c_ST_DONE    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/gray_align_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_align_lane : one channel's extended mantissa and shift counter      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gray_align_lane
  import gray_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_load,
  input  logic [MANT_W-1:0] i_mant,
  input  logic              i_load_cnt,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic              i_step,
  output logic [EXT_W-1:0]  o_mant,
  output logic              o_cnt_zero
);

  logic [EXT_W-1:0] r_mant;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mant <= '0;
      r_cnt  <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_mant <= {i_mant, {GUARD_W{1'b0}}};
        r_cnt  <= '0;
      end else if (i_load_cnt) begin
        r_cnt <= i_cnt;
      end else if (i_step && (r_cnt != '0)) begin
        // Truncating shift: bits falling off the guard LSB are dropped
        r_mant <= r_mant >> 1;
        r_cnt  <= r_cnt - 1'b1;
      end
    end
  end

  assign o_mant     = r_mant;
  assign o_cnt_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/gray_fp_sum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_fp_sum : align, add and round three weighted channels to gray       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gray_fp_sum
  import gray_pkg::*;
(
  input  logic                    clk_i_gray_sum,
  input  logic                    rst_i_gray_sum,
  input  logic                    en_i_gray_sum,
  input  logic                    start_i,
  input  logic [MANT_W-1:0]       mant_i_R,
  input  logic [MANT_W-1:0]       mant_i_G,
  input  logic [MANT_W-1:0]       mant_i_B,
  input  logic signed [EXP_W-1:0] exp_i_R,
  input  logic signed [EXP_W-1:0] exp_i_G,
  input  logic signed [EXP_W-1:0] exp_i_B,
  output logic [PIXEL_WIDTH-1:0]  gray_o,
  output logic                    done_o,
  output logic                    busy_o
);

  localparam int VAL_W = SUM_W + PIXEL_WIDTH;
  localparam int KSH_W = $clog2(SUM_W + 1);
  localparam int K_W   = EXP_W + 2;

  state_t                  r_state;
  logic signed [EXP_W-1:0] r_exp [NUM_CH];
  logic signed [EXP_W-1:0] r_emax;
  logic [SUM_W-1:0]        r_sum;
  logic [PIXEL_WIDTH-1:0]  r_gray;
  logic                    r_done;

  logic [MANT_W-1:0]       w_mant_in   [NUM_CH];
  logic signed [EXP_W-1:0] w_exp_in    [NUM_CH];
  logic [EXT_W-1:0]        w_lane_mant [NUM_CH];
  logic [CNT_W-1:0]        w_cnt       [NUM_CH];
  logic signed [EXP_W:0]   w_diff      [NUM_CH];
  logic [NUM_CH-1:0]       w_cnt_zero;
  logic signed [EXP_W-1:0] w_emax;
  logic                    w_any;
  logic                    w_load;
  logic                    w_load_cnt;
  logic                    w_step;
  logic [SUM_W-1:0]        w_sum;
  logic signed [K_W-1:0]   w_k;
  logic [K_W-1:0]          w_nk;
  logic [KSH_W-1:0]        w_sh;
  logic [SUM_W:0]          w_rnd;
  logic [VAL_W-1:0]        w_val;
  logic [PIXEL_WIDTH-1:0]  w_gray;

  assign w_mant_in[CH_R] = mant_i_R;
  assign w_mant_in[CH_G] = mant_i_G;
  assign w_mant_in[CH_B] = mant_i_B;
  assign w_exp_in[CH_R]  = exp_i_R;
  assign w_exp_in[CH_G]  = exp_i_G;
  assign w_exp_in[CH_B]  = exp_i_B;

  assign w_load     = (r_state == c_ST_IDLE) && start_i;
  assign w_load_cnt = (r_state == c_ST_MAXEXP);
  assign w_step     = (r_state == c_ST_ALIGN);

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      gray_align_lane u_lane (
        .clk        (clk_i_gray_sum),
        .rst        (rst_i_gray_sum),
        .i_en       (en_i_gray_sum),
        .i_load     (w_load),
        .i_mant     (w_mant_in[g]),
        .i_load_cnt (w_load_cnt),
        .i_cnt      (w_cnt[g]),
        .i_step     (w_step),
        .o_mant     (w_lane_mant[g]),
        .o_cnt_zero (w_cnt_zero[g])
      );
    end
  endgenerate

  // Zero-mantissa channels never contribute to emax; all-zero leaves emax at 0
  always_comb begin
    w_emax = '0;
    w_any  = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if ((w_lane_mant[ch] != '0) && (!w_any || (r_exp[ch] > w_emax))) begin
        w_emax = r_exp[ch];
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_diff[ch] = (EXP_W+1)'(w_emax) - (EXP_W+1)'(r_exp[ch]);
      w_cnt[ch]  = '0;
      if (w_lane_mant[ch] != '0) begin
        if (w_diff[ch] > (EXP_W+1)'(MAX_SHIFT))
          w_cnt[ch] = CNT_W'(MAX_SHIFT);
        else
          w_cnt[ch] = w_diff[ch][CNT_W-1:0];
      end
    end
  end

  assign w_sum = SUM_W'(w_lane_mant[CH_R]) + SUM_W'(w_lane_mant[CH_G])
               + SUM_W'(w_lane_mant[CH_B]);

  // k = binary point position of the sum relative to the integer LSB
  always_comb begin
    w_k   = K_W'(EXT_W - 1) - K_W'(r_emax);
    w_nk  = -w_k;
    w_sh  = w_k[KSH_W-1:0];
    w_rnd = '0;
    w_val = '0;
    if (w_k > K_W'(0)) begin
      if (w_k <= K_W'(SUM_W)) begin
        w_rnd = ({1'b0, r_sum} + ((SUM_W+1)'(1) << (w_sh - KSH_W'(1)))) >> w_sh;
        w_val = VAL_W'(w_rnd);
      end
    end else if (w_nk >= K_W'(PIXEL_WIDTH)) begin
      w_val = (r_sum != '0) ? '1 : '0;
    end else begin
      w_val = VAL_W'(r_sum) << w_nk;
    end
    w_gray = (w_val[VAL_W-1:PIXEL_WIDTH] != '0) ? '1 : w_val[PIXEL_WIDTH-1:0];
  end

  always_ff @(posedge clk_i_gray_sum) begin
    if (rst_i_gray_sum) begin
      r_state <= c_ST_IDLE;
      r_emax  <= '0;
      r_sum   <= '0;
      r_gray  <= '0;
      r_done  <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) r_exp[ch] <= '0;
    end else if (en_i_gray_sum) begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start_i) begin
            for (int ch = 0; ch < NUM_CH; ch++) r_exp[ch] <= w_exp_in[ch];
            r_state <= c_ST_MAXEXP;
          end
        end
        c_ST_MAXEXP: begin
          r_emax  <= w_emax;
          r_state <= c_ST_ALIGN;
        end
        c_ST_ALIGN: begin
          if (&w_cnt_zero) r_state <= c_ST_ADD;
        end
        c_ST_ADD: begin
          r_sum   <= w_sum;
          r_state <= c_ST_CONVERT;
        end
        c_ST_CONVERT: begin
          r_gray  <= w_gray;
          r_done  <= 1'b1;
          r_state <= c_ST_DONE;
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign gray_o = r_gray;
  assign done_o = r_done;
  assign busy_o = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gray_fp_sum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gray_fp_sum : vector table plus scoreboard for gray_fp_sum            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_gray_fp_sum;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              start;
  logic [9:0]        mr, mg, mb;
  logic signed [5:0] er, eg, eb;
  logic [7:0]        gray;
  logic              done;
  logic              busy;

  always #5 clk = ~clk;

  gray_fp_sum dut (
    .clk_i_gray_sum (clk),
    .rst_i_gray_sum (rst),
    .en_i_gray_sum  (en),
    .start_i        (start),
    .mant_i_R       (mr),
    .mant_i_G       (mg),
    .mant_i_B       (mb),
    .exp_i_R        (er),
    .exp_i_G        (eg),
    .exp_i_B        (eb),
    .gray_o         (gray),
    .done_o         (done),
    .busy_o         (busy)
  );

  typedef struct {
    logic [9:0]        mr, mg, mb;
    logic signed [5:0] er, eg, eb;
    logic [7:0]        gray;
    int                lat;
  } vec_t;

  typedef struct {
    logic [7:0] gray;
    int         lat;
    int         busy;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(int a, int b, int c, int d, int e, int f, int g, int l);
    vec_t v;
    v.mr = 10'(a); v.mg = 10'(b); v.mb = 10'(c);
    v.er = 6'(d);  v.eg = 6'(e);  v.eb = 6'(f);
    v.gray = 8'(g);
    v.lat  = l;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drives one operation; optional start poke while busy and an enable stall
  task automatic run_op(input vec_t v, input int poke_at, input int stall_at,
                        input int stall_len, input string tag);
    exp_t       e;
    exp_t       got;
    int         nb;
    int         nd;
    int         lat;
    logic [7:0] g;
    e.gray = v.gray;
    e.lat  = v.lat + stall_len;
    e.busy = v.lat + 1 + stall_len;
    sb.push_back(e);
    mr = v.mr; mg = v.mg; mb = v.mb;
    er = v.er; eg = v.eg; eb = v.eb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0; nd = 0; lat = -1; g = '0;
    for (int c = 0; c < 60; c++) begin
      if (!busy) break;
      if (c == poke_at) begin
        start = 1'b1;
        mr = 10'd1023; mg = 10'd1023; mb = 10'd1023;
        er = 6'sd7;    eg = 6'sd7;    eb = 6'sd7;
      end
      if (c == poke_at + 1) start = 1'b0;
      if (c == stall_at) en = 1'b0;
      if (c == stall_at + stall_len) en = 1'b1;
      nb++;
      if (done) begin
        nd++;
        lat = c;
        g = gray;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    en    = 1'b1;
    check({tag, " idle_at_end"}, int'(busy), 0);
    check({tag, " done_pulses"}, nd, 1);
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 1, 0);
    end else begin
      got = sb.pop_front();
      check({tag, " gray"}, int'(g), int'(got.gray));
      check({tag, " latency"}, lat, got.lat);
      check({tag, " busy_cycles"}, nb, got.busy);
      check({tag, " gray_hold"}, int'(gray), int'(got.gray));
    end
  endtask

  initial begin
    int nd;
    vecs[0] = mk( 512,  512,  512,  0,  0,  0,   3,  4);
    vecs[1] = mk( 768,  512,  512,  5,  6,  3, 120,  7);
    vecs[2] = mk(1023, 1023, 1023,  7,  7,  7, 255,  4);
    vecs[3] = mk(   0,    0,    0, -5, 20,  3,   0,  4);
    vecs[4] = mk(   0,  512,    0,  7,  2,  0,   4,  4);
    vecs[5] = mk( 768,    0,    0,  0,  0,  0,   2,  4);
    vecs[6] = mk( 512,  512,    0,  7, -6,  0, 128, 16);
    vecs[7] = mk( 512,    0,    0, 11,  0,  0, 255,  4);
    vecs[8] = mk( 512,  512,  512, -3, -3, -3,   0,  4);
    vecs[9] = mk( 600,  700,  800,  4,  4,  2,  47,  6);

    rst = 1'b1; en = 1'b1; start = 1'b0;
    mr = '0; mg = '0; mb = '0; er = '0; eg = '0; eb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset gray", int'(gray), 0);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], -10, -10, 0, $sformatf("vec%0d", i));
    end

    // Start pulse while busy must not disturb the running operation
    run_op(vecs[0], 2, -10, 0, "poke_busy");

    // Three stalled cycles mid-operation push done out by exactly three
    run_op(vecs[1], -10, 2, 3, "stall3");

    // Reset during ALIGN aborts: no done, outputs cleared
    mr = vecs[6].mr; mg = vecs[6].mg; mb = vecs[6].mb;
    er = vecs[6].er; eg = vecs[6].eg; eb = vecs[6].eb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort busy_before", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort gray", int'(gray), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("abort no_done", nd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_fp_sum.md
# gray_fp_sum

Final stage of the RGB-to-grayscale path. It takes the three weighted channel products from the fixed-point multiplier (a normalized mantissa plus a signed exponent for each of R, G and B) and aligns them to a common exponent. It then adds them and converts the sum to a rounded, saturated 8-bit gray pixel. Align, add and convert run as an iterative FSM started by the multiplier's done pulse.

## Interface
- MANT_W, 10: channel mantissa width; value = mant/2^(MANT_W-1), bit MANT_W-1 is the hidden 1
- EXP_W, 6: signed channel exponent width
- GUARD_W, 2: guard bits appended below mantissa LSB during alignment
- PIXEL_WIDTH, 8: output gray width
- MAX_SHIFT, 12: alignment shift cap (MANT_W+GUARD_W)

Ports:
- clk_i_gray_sum  in  1  clock
- rst_i_gray_sum  in  1  reset; synchronous, active-high
- en_i_gray_sum  in  1  clock enable; low freezes all state
- start_i  in  1  pulse; capture operands (driven by multiplier done)
- mant_i_R / mant_i_G / mant_i_B  in  MANT_W  channel mantissa; 0 means channel value zero
- exp_i_R / exp_i_G / exp_i_B  in  EXP_W signed  channel exponent; value = mant × 2^(exp-(MANT_W-1))
- gray_o  out  PIXEL_WIDTH  result; holds until next DONE
- done_o  out  1  one-cycle pulse; gray_o valid
- busy_o  out  1  high whenever state ≠ IDLE

## Operation
- Reset priority: rst beats en. Reset forces state IDLE, gray_o=0, done_o=0, busy_o=0, and clears all internal registers. Reset mid-operation aborts with no done_o.
- States: IDLE → MAXEXP → ALIGN → ADD → CONVERT → DONE → IDLE.
- IDLE: on start_i=1, latch all six inputs, extend each mantissa to MANT_W+GUARD_W by appending GUARD_W zeros, and go to MAXEXP. start_i in any other state is ignored.
- MAXEXP:
  - emax = max exponent over channels with mant≠0.
  - Per-channel shift count = min(emax−exp, MAX_SHIFT); 0 for zero channels.
  - If all channels are zero, emax=0 and all counts are 0.
- ALIGN: each cycle, every lane with count>0 shifts right 1 (truncating, no sticky) and decrements its count. Go to ADD when all counts are 0; a cycle with all counts 0 on entry goes straight to ADD.
- ADD: sum = R+G+B, width MANT_W+GUARD_W+2 (14 bits), never overflows.
- CONVERT: k = (MANT_W+GUARD_W−1) − emax.
  - k>0: val = (sum + 2^(k−1)) >> k, round half up; k ≥ 15 → 0.
  - k≤0: val = sum << −k.
  - val > 255 saturates to 255. Register into gray_o.
- DONE: done_o=1 for this cycle only; return to IDLE.

## Timing
- start_i sampled at edge N; D = largest shift count after saturation (0..12).
- Edge N+4+D enters DONE: done_o is high and gray_o is updated for that one cycle. Edge N+5+D returns to IDLE.
- Latency is 4 cycles minimum and 16 cycles maximum.
- Next start is accepted in the first IDLE cycle; back-to-back throughput is one result per 6+D cycles.
- en low stalls all cycle counts; done_o holds its level while stalled.

## Structure
- Shared package gray_pkg holds:
  - state encoding (3-bit localparams)
  - MANT_W, EXP_W, GUARD_W, MAX_SHIFT and the derived sum width
  - channel constants shared with the multiplier
- Sub-module gray_align_lane, instantiated ×3. It holds one channel's extended mantissa register and 4-bit shift counter, and provides load, step and zero-count outputs.
- Top level holds the FSM, emax compare, adder and converter.

## Test plan
- Equal values: all mant=512, exp=0 → gray_o=3, D=0, done_o at edge N+4, busy_o high for 5 cycles.
- Exponent alignment: R 768/exp5, G 512/exp6, B 512/exp3 → sum 3840, gray_o=120, latency 7.
- Saturation: all mant=1023, exp=7 → gray_o=255.
- Zero handling:
  - All mant=0 with arbitrary exponents → gray_o=0, latency 4.
  - R 0/exp7, G 512/exp2, B 0 → gray_o=4 (zero channel does not set emax).
- Rounding and shift cap:
  - R 768/exp0, others 0 → 1.5 rounds to gray_o=2.
  - R 512/exp7, G 512/exp−6 → G count caps at 12, gray_o=128, latency 16.
- Control:
  - Assert rst_i_gray_sum during ALIGN → IDLE, gray_o=0, no done_o.
  - start_i while busy → ignored, result unchanged.
  - en low for 3 cycles mid-op → done_o delayed by exactly 3 cycles.
